pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_ctrl_pkg.sv | 29 ++
 rtl/pipe_hazard_ctrl_if.sv | 39 +++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Output vector bit order: pc_write, if_id_write, if_id_clear, id_ex_bubble, halted.
package pipe_hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } state_t;

  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_clear;
    logic id_ex_bubble;
    logic halted;
  } ctrl_t;

  localparam ctrl_t VEC_RUN    = 5'b11000;
  localparam ctrl_t VEC_FREEZE = 5'b00000;
  localparam ctrl_t VEC_STALL  = 5'b00010;
  localparam ctrl_t VEC_FLUSH  = 5'b10110;
  localparam ctrl_t VEC_HALT   = 5'b00011;
  localparam ctrl_t VEC_RESET  = 5'b00110;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// master = datapath side, slave = controller side.
interface pipe_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic [REG_ADDR_W-1:0] ex_rt;
  logic                  id_uses_rt;
  logic                  id_halt;
  logic                  ex_mem_read;
  logic                  branch_taken;
  logic                  mem_busy;
  logic                  pc_write;
  logic                  if_id_write;
  logic                  if_id_clear;
  logic                  id_ex_bubble;
  logic                  halted;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;
  logic [CNT_W-1:0]      wait_cnt;

  modport master (
    output id_rs, id_rt, ex_rt, id_uses_rt, id_halt,
    output ex_mem_read, branch_taken, mem_busy,
    input  pc_write, if_id_write, if_id_clear,
    input  id_ex_bubble, halted,
    input  stall_cnt, flush_cnt, wait_cnt
  );

  modport slave (
    input  id_rs, id_rt, ex_rt, id_uses_rt, id_halt,
    input  ex_mem_read, branch_taken, mem_busy,
    output pc_write, if_id_write, if_id_clear,
    output id_ex_bubble, halted,
    output stall_cnt, flush_cnt, wait_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: EX load target against ID sources.
// Register 0 is hardwired and never creates a dependency.
module hazard_detect
  import pipe_hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  output logic                  lu
);
  logic rs_hit;
  logic rt_hit;
  logic nz;

  assign nz     = ex_rt != REG_ADDR_W'(REG_ZERO);
  assign rs_hit = ex_rt == id_rs;
  assign rt_hit = id_uses_rt && (ex_rt == id_rt);
  assign lu     = ex_mem_read && nz && (rs_hit || rt_hit);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller: load-use stalls, branch flushes, memory freezes, HALT.
// Optional statistics counters built only when HAZARD_STATS_EN is defined.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int BR_PENALTY = 1,
  parameter int CNT_W      = 16
) (
  input logic              clock,
  input logic              clear,
  pipe_hazard_ctrl_if.slave bus
);

  generate
    if (BR_PENALTY < 1 || BR_PENALTY > 3) begin : g_bad_penalty
      $error("BR_PENALTY must be in 1..3");
    end
  endgenerate

  localparam logic [1:0] FLUSH_INIT = 2'(BR_PENALTY - 1);

  state_t     st;
  state_t     st_nxt;
  state_t     ret_st;
  state_t     ret_nxt;
  logic [1:0] fcnt;
  logic [1:0] fcnt_nxt;
  ctrl_t      vec;
  logic       lu;

  logic sel_busy;
  logic sel_br;
  logic sel_lu;
  logic sel_halt;

  hazard_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_detect (
    .id_rs      (bus.id_rs),
    .id_rt      (bus.id_rt),
    .id_uses_rt (bus.id_uses_rt),
    .ex_mem_read(bus.ex_mem_read),
    .ex_rt      (bus.ex_rt),
    .lu         (lu)
  );

  // One-hot priority decode: mem_busy > branch > load-use > halt
  assign sel_busy = bus.mem_busy;
  assign sel_br   = !bus.mem_busy && bus.branch_taken;
  assign sel_lu   = !bus.mem_busy && !bus.branch_taken && lu;
  assign sel_halt = !bus.mem_busy && !bus.branch_taken &&
                    !lu && bus.id_halt;

  always_comb begin
    st_nxt   = st;
    ret_nxt  = ret_st;
    fcnt_nxt = fcnt;
    vec      = VEC_RUN;
    unique case (st)
      RUN: begin
        unique case (1'b1)
          sel_busy: begin
            vec     = VEC_FREEZE;
            ret_nxt = RUN;
            st_nxt  = MEM_WAIT;
          end
          sel_br: begin
            vec = VEC_FLUSH;
            if (BR_PENALTY > 1) begin
              fcnt_nxt = FLUSH_INIT;
              st_nxt   = FLUSH;
            end
          end
          sel_lu: vec = VEC_STALL;
          sel_halt: begin
            vec    = VEC_FREEZE;
            st_nxt = HALT;
          end
          default: vec = VEC_RUN;
        endcase
      end
      FLUSH: begin
        if (bus.mem_busy) begin
          vec     = VEC_FREEZE;
          ret_nxt = FLUSH;
          st_nxt  = MEM_WAIT;
        end else begin
          vec      = VEC_FLUSH;
          fcnt_nxt = fcnt - 2'd1;
          if (fcnt == 2'd1) st_nxt = RUN;
        end
      end
      MEM_WAIT: begin
        vec = VEC_FREEZE;
        if (!bus.mem_busy) st_nxt = ret_st;
      end
      HALT: vec = VEC_HALT;
    endcase
    if (!clear) vec = VEC_RESET;
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      st     <= RUN;
      ret_st <= RUN;
      fcnt   <= 2'd0;
    end else begin
      st     <= st_nxt;
      ret_st <= ret_nxt;
      fcnt   <= fcnt_nxt;
    end
  end

  assign bus.pc_write     = vec.pc_write;
  assign bus.if_id_write  = vec.if_id_write;
  assign bus.if_id_clear  = vec.if_id_clear;
  assign bus.id_ex_bubble = vec.id_ex_bubble;
  assign bus.halted       = vec.halted;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;
  logic [CNT_W-1:0] wait_q;
  logic             inc_stall;
  logic             inc_flush;
  logic             inc_wait;

  assign inc_stall = (st == RUN) && sel_lu;
  assign inc_flush = vec.if_id_clear;
  assign inc_wait  = st == MEM_WAIT;

  // Counters saturate rather than wrap
  always_ff @(posedge clock) begin
    if (!clear) begin
      stall_q <= '0;
      flush_q <= '0;
      wait_q  <= '0;
    end else begin
      if (inc_stall && !(&stall_q)) stall_q <= stall_q + 1'b1;
      if (inc_flush && !(&flush_q)) flush_q <= flush_q + 1'b1;
      if (inc_wait && !(&wait_q))   wait_q  <= wait_q + 1'b1;
    end
  end

  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
  assign bus.wait_cnt  = wait_q;
`else
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
  assign bus.wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed plan plus random traffic.
// Expected vector order: pc_write, if_id_write, if_id_clear, bubble, halted.
module tb_pipe_hazard_ctrl;
  localparam int RW = 5;
  localparam int BP = 3;
  localparam int CW = 16;

  localparam logic [4:0] E_RUN   = 5'b11000;
  localparam logic [4:0] E_FRZ   = 5'b00000;
  localparam logic [4:0] E_STALL = 5'b00010;
  localparam logic [4:0] E_FLUSH = 5'b10110;
  localparam logic [4:0] E_HALT  = 5'b00011;
  localparam logic [4:0] E_RST   = 5'b00110;

  logic clock = 1'b0;
  logic clear = 1'b0;
  always #5 clock = ~clock;

  pipe_hazard_ctrl_if #(.REG_ADDR_W(RW), .CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(
    .REG_ADDR_W(RW),
    .BR_PENALTY(BP),
    .CNT_W     (CW)
  ) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus)
  );

  typedef struct {
    string      tag;
    logic [4:0] v;
    bit         cc;
    int         sc;
    int         fc;
    int         wc;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  // Reference model: remaining flush slots, a waiting flag and a halted flag
  bit m_halted = 0;
  bit m_wait   = 0;
  int m_left   = 0;
  bit m_known  = 0;
  int m_sc = 0, m_fc = 0, m_wc = 0;

  function automatic int sat(input int x);
    return (x >= (1 << CW) - 1) ? (1 << CW) - 1 : x + 1;
  endfunction

  task automatic step(input string tag, input bit clr, input bit br,
                      input bit mb, input bit ld, input int ert,
                      input int rs, input int rt, input bit urt,
                      input bit hlt);
    exp_t e;
    bit lu;
    @(posedge clock);
    #1;
    clear            = clr;
    bus.branch_taken = br;
    bus.mem_busy     = mb;
    bus.ex_mem_read  = ld;
    bus.ex_rt        = RW'(ert);
    bus.id_rs        = RW'(rs);
    bus.id_rt        = RW'(rt);
    bus.id_uses_rt   = urt;
    bus.id_halt      = hlt;
    lu = ld && ert != 0 && (ert == rs || (urt && ert == rt));
    e.tag = tag;
    e.cc  = m_known;
    e.sc  = m_sc;
    e.fc  = m_fc;
    e.wc  = m_wc;
    if (!clr) begin
      e.v = E_RST;
      m_halted = 0; m_wait = 0; m_left = 0;
      m_sc = 0; m_fc = 0; m_wc = 0;
      m_known = 1;
    end else if (m_halted) begin
      e.v = E_HALT;
    end else if (m_wait) begin
      e.v = E_FRZ;
      m_wc = sat(m_wc);
      if (!mb) m_wait = 0;
    end else if (mb) begin
      e.v = E_FRZ;
      m_wait = 1;
    end else if (m_left > 0) begin
      e.v = E_FLUSH;
      m_left--;
    end else if (br) begin
      e.v = E_FLUSH;
      m_left = BP - 1;
    end else if (lu) begin
      e.v = E_STALL;
      m_sc = sat(m_sc);
    end else if (hlt) begin
      e.v = E_FRZ;
      m_halted = 1;
    end else begin
      e.v = E_RUN;
    end
    if (clr && e.v[2]) m_fc = sat(m_fc);
    q.push_back(e);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rnd(input string tag, input bit clr, input bit busy_ok);
    step(tag, clr,
         $urandom_range(5) == 0,
         busy_ok && $urandom_range(5) == 0,
         $urandom_range(2) == 0,
         $urandom_range(3), $urandom_range(3), $urandom_range(3),
         $urandom_range(1) == 1,
         $urandom_range(29) == 0);
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [4:0] act;
      int ws, wf, ww;
      e = q.pop_front();
      act = {bus.pc_write, bus.if_id_write, bus.if_id_clear,
             bus.id_ex_bubble, bus.halted};
      n_chk++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL %s ctrl: got %b want %b @%0t", e.tag, act, e.v, $time);
      end
      if (e.cc) begin
`ifdef HAZARD_STATS_EN
        ws = e.sc; wf = e.fc; ww = e.wc;
`else
        ws = 0; wf = 0; ww = 0;
`endif
        n_chk++;
        if (bus.stall_cnt !== CW'(ws) || bus.flush_cnt !== CW'(wf) ||
            bus.wait_cnt !== CW'(ww)) begin
          n_fail++;
          $display("FAIL %s cnt: got %0d/%0d/%0d want %0d/%0d/%0d @%0t",
                   e.tag, bus.stall_cnt, bus.flush_cnt, bus.wait_cnt,
                   ws, wf, ww, $time);
        end
      end
    end
  end

  initial begin
    int w;
    bus.branch_taken = 0; bus.mem_busy = 0; bus.ex_mem_read = 0;
    bus.ex_rt = '0; bus.id_rs = '0; bus.id_rt = '0;
    bus.id_uses_rt = 0; bus.id_halt = 0;

    for (int i = 0; i < 3; i++) rnd("reset", 0, 1);
    idle("release", 2);

    step("lu_rs", 1, 0, 0, 1, 5, 5, 1, 0, 0);
    idle("lu_after", 2);
    step("lu_rt", 1, 0, 0, 1, 7, 2, 7, 1, 0);
    step("lu_rt_off", 1, 0, 0, 1, 7, 2, 7, 0, 0);
    step("lu_r0", 1, 0, 0, 1, 0, 0, 0, 1, 0);
    idle("lu_idle", 1);

    step("branch", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step("flush_br_ign", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    idle("flush_tail", 3);

    step("mw_branch", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("mw_busy", 1, 0, 1, 0, 0, 0, 0, 0, 0);
    idle("mw_resume", 4);

    step("prio", 1, 1, 1, 1, 3, 3, 0, 0, 1);
    step("prio_rel", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle("prio_run", 2);

    step("halt", 1, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++)
      step("halt_hold", 1, i[0], i[1], 1, 2, 2, 2, 1, 0);
    step("halt_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle("halt_exit", 2);

    for (int i = 0; i < 600; i++) rnd("random", $urandom_range(39) != 0, 1);

    w = 0;
    while (q.size() > 0 && w < 20) begin
      @(posedge clock);
      w++;
    end
    n_chk++;
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
